// File: rtl/chain_unmix_if.sv
// rtl/chain_unmix_if.sv - serial in/out stream bundle for chain_unmix
interface chain_unmix_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/chain_unmix.sv
// rtl/chain_unmix.sv - iterative inverse of the 8-word add/subtract chain mixer
module chain_unmix #(
  parameter int ROUNDS = 11,
  parameter int W      = 32
) (
  input  logic          clk,
  input  logic          rst,
  chain_unmix_if.slave  bus
);
  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [RW-1:0] R_LAST = RW'((ROUNDS > 0) ? ROUNDS - 1 : 0);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    k_q, k_d;
  logic [RW-1:0] r_q, r_d;
  logic [W-1:0]  s_q [8];
  logic [W-1:0]  s_d [8];
  logic [2:0]    k_m1, k_m2;

  // Neighbour indices wrap mod 8 through the 3-bit subtraction.
  assign k_m1 = k_q - 3'd1;
  assign k_m2 = k_q - 3'd2;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    r_d     = r_q;
    s_d     = s_q;
    case (state_q)
      LOAD: begin
        if (bus.in_valid) begin
          s_d[k_q] = bus.in_data;
          k_d      = k_q + 3'd1;
          if (k_q == 3'd7) begin
            r_d = '0;
            if (ROUNDS == 0) begin
              state_d = DRAIN;
              k_d     = 3'd0;
            end else begin
              state_d = RUN;
              k_d     = 3'd7;
            end
          end
        end
      end
      RUN: begin
        // Walk i = 7..0 so each step sees the neighbours the forward round used.
        s_d[k_q] = s_q[k_q] - (s_q[k_m1] - s_q[k_m2]);
        k_d      = k_q - 3'd1;
        if (k_q == 3'd0) begin
          r_d = r_q + 1'b1;
          if (r_q == R_LAST) begin
            state_d = DRAIN;
            k_d     = 3'd0;
          end
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          k_d = k_q + 3'd1;
          if (k_q == 3'd7) begin
            state_d = LOAD;
            k_d     = 3'd0;
          end
        end
      end
      default: begin
        state_d = LOAD;
        k_d     = 3'd0;
        r_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      k_q     <= 3'd0;
      r_q     <= '0;
      for (int i = 0; i < 8; i++) begin
        s_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      r_q     <= r_d;
      for (int i = 0; i < 8; i++) begin
        s_q[i] <= s_d[i];
      end
    end
  end

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.out_valid = (state_q == DRAIN);
  assign bus.busy      = (state_q != LOAD);
  assign bus.out_data  = (state_q == DRAIN) ? s_q[k_q] : '0;
endmodule

// File: tb/tb_chain_unmix.sv
// tb/tb_chain_unmix.sv - directed scoreboard bench for chain_unmix at ROUNDS 1, 11 and 0
module tb_chain_unmix;
  typedef logic [31:0] frame_t [8];

  logic clk;
  logic rst;

  logic        in_valid_d  [3];
  logic [31:0] in_data_d   [3];
  logic        out_ready_d [3];
  logic        in_ready_w  [3];
  logic        out_valid_w [3];
  logic [31:0] out_data_w  [3];
  logic        busy_w      [3];

  int checks   = 0;
  int failures = 0;
  logic [31:0] sb_q [$];

  chain_unmix_if #(.W(32)) if_a ();
  chain_unmix_if #(.W(32)) if_b ();
  chain_unmix_if #(.W(32)) if_c ();

  chain_unmix #(.ROUNDS(1),  .W(32)) u_r1  (.clk(clk), .rst(rst), .bus(if_a));
  chain_unmix #(.ROUNDS(11), .W(32)) u_r11 (.clk(clk), .rst(rst), .bus(if_b));
  chain_unmix #(.ROUNDS(0),  .W(32)) u_r0  (.clk(clk), .rst(rst), .bus(if_c));

  assign if_a.in_valid  = in_valid_d[0];
  assign if_a.in_data   = in_data_d[0];
  assign if_a.out_ready = out_ready_d[0];
  assign if_b.in_valid  = in_valid_d[1];
  assign if_b.in_data   = in_data_d[1];
  assign if_b.out_ready = out_ready_d[1];
  assign if_c.in_valid  = in_valid_d[2];
  assign if_c.in_data   = in_data_d[2];
  assign if_c.out_ready = out_ready_d[2];

  assign in_ready_w[0]  = if_a.in_ready;
  assign out_valid_w[0] = if_a.out_valid;
  assign out_data_w[0]  = if_a.out_data;
  assign busy_w[0]      = if_a.busy;
  assign in_ready_w[1]  = if_b.in_ready;
  assign out_valid_w[1] = if_b.out_valid;
  assign out_data_w[1]  = if_b.out_data;
  assign busy_w[1]      = if_b.busy;
  assign in_ready_w[2]  = if_c.in_ready;
  assign out_valid_w[2] = if_c.out_valid;
  assign out_data_w[2]  = if_c.out_data;
  assign busy_w[2]      = if_c.busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Forward mixer rounds: the reference the unmixer must undo.
  function automatic frame_t fwd(input frame_t s_in, input int rounds);
    frame_t s;
    s = s_in;
    for (int rr = 0; rr < rounds; rr++) begin
      for (int i = 0; i < 8; i++) begin
        s[i] = s[i] + s[(i + 7) % 8] - s[(i + 6) % 8];
      end
    end
    return s;
  endfunction

  task automatic push_frame(input frame_t f);
    for (int i = 0; i < 8; i++) sb_q.push_back(f[i]);
  endtask

  task automatic send_frame(input int sel, input frame_t w, input bit rnd);
    int  i;
    int  g;
    bit  v;
    bit  acc;
    i = 0;
    g = 0;
    while (i < 8 && g < 400) begin
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid_d[sel] = v;
      in_data_d[sel]  = w[i];
      acc = v && in_ready_w[sel];
      @(negedge clk);
      if (acc) i++;
      g++;
    end
    in_valid_d[sel] = 1'b0;
    check("load_beats", 32'(i), 32'd8);
  endtask

  task automatic wait_out(input int sel, input int exp_lat);
    int cnt;
    cnt = 0;
    check("busy_rise", 32'(busy_w[sel]), 32'd1);
    while (!out_valid_w[sel] && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    check("latency", 32'(cnt), 32'(exp_lat));
  endtask

  task automatic drain_frame(input int sel, input int stall_at, input int stall_len);
    int          n;
    int          g;
    int          stall;
    bit          acc;
    logic [31:0] held;
    logic [31:0] exp;
    n = 0;
    g = 0;
    stall = 0;
    held = '0;
    while (n < 8 && g < 400) begin
      if (n == stall_at && stall < stall_len) begin
        out_ready_d[sel] = 1'b0;
        if (stall == 0) held = out_data_w[sel];
        else begin
          check("stall_data", out_data_w[sel], held);
          check("stall_valid", 32'(out_valid_w[sel]), 32'd1);
        end
        stall++;
      end else begin
        out_ready_d[sel] = 1'b1;
      end
      acc = out_valid_w[sel] && out_ready_d[sel];
      if (acc) begin
        if (sb_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
        else begin
          exp = sb_q.pop_front();
          check("out_word", out_data_w[sel], exp);
        end
        n++;
      end
      @(negedge clk);
      g++;
    end
    out_ready_d[sel] = 1'b0;
    check("drain_beats", 32'(n), 32'd8);
    check("ready_after", 32'(in_ready_w[sel]), 32'd1);
    check("busy_after", 32'(busy_w[sel]), 32'd0);
  endtask

  initial begin
    frame_t plain;
    frame_t vec;
    for (int s = 0; s < 3; s++) begin
      in_valid_d[s]  = 1'b0;
      in_data_d[s]   = '0;
      out_ready_d[s] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check("rst_in_ready", 32'(in_ready_w[s]), 32'd1);
      check("rst_out_valid", 32'(out_valid_w[s]), 32'd0);
      check("rst_out_data", out_data_w[s], 32'd0);
      check("rst_busy", 32'(busy_w[s]), 32'd0);
    end

    // ROUNDS=1 known vector
    vec = '{32'h00000001, 32'hFFFFFFFB, 32'hFFFFFFFC, 32'h00000004,
            32'h0000000C, 32'h0000000D, 32'h00000007, 32'h00000001};
    for (int i = 0; i < 8; i++) plain[i] = 32'(i);
    push_frame(plain);
    send_frame(0, vec, 1'b0);
    wait_out(0, 8);
    drain_frame(0, -1, 0);

    // ROUNDS=11 round trip, then a random frame back-to-back
    push_frame(plain);
    send_frame(1, fwd(plain, 11), 1'b0);
    wait_out(1, 88);
    drain_frame(1, -1, 0);
    for (int i = 0; i < 8; i++) plain[i] = $urandom;
    push_frame(plain);
    send_frame(1, fwd(plain, 11), 1'b0);
    wait_out(1, 88);
    drain_frame(1, -1, 0);

    // ROUNDS=0 identity
    vec = '{32'hA5A5A5A5, 32'h00000000, 32'hFFFFFFFF, 32'h00000001,
            32'h00000002, 32'h00000003, 32'h00000004, 32'h00000005};
    check("r0_busy_idle", 32'(busy_w[2]), 32'd0);
    push_frame(vec);
    send_frame(2, vec, 1'b0);
    wait_out(2, 0);
    drain_frame(2, -1, 0);

    // Backpressure: ragged input, 5-cycle output stall
    for (int i = 0; i < 8; i++) plain[i] = $urandom;
    push_frame(plain);
    send_frame(1, fwd(plain, 11), 1'b1);
    wait_out(1, 88);
    drain_frame(1, 3, 5);

    // Reset during round 3: frame is discarded, nothing pushed
    for (int i = 0; i < 8; i++) plain[i] = $urandom;
    send_frame(1, fwd(plain, 11), 1'b0);
    repeat (27) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready_w[1]), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid_w[1]), 32'd0);
    check("mid_rst_busy", 32'(busy_w[1]), 32'd0);
    check("mid_rst_out_data", out_data_w[1], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // All-zero frame with ROUNDS=11
    for (int i = 0; i < 8; i++) plain[i] = '0;
    push_frame(plain);
    send_frame(1, plain, 1'b0);
    wait_out(1, 88);
    drain_frame(1, -1, 0);

    // All-ones frame with ROUNDS=1
    for (int i = 0; i < 8; i++) plain[i] = 32'hFFFFFFFF;
    push_frame(plain);
    send_frame(0, plain, 1'b0);
    wait_out(0, 8);
    drain_frame(0, -1, 0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
